lutram_fifo32: RTL and testbench
================================

Name: lutram_fifo32

Overview:
- 32-entry synchronous FIFO built on a 32 x DATA_WIDTH distributed (LUT) RAM: synchronous write, asynchronous read.
- Sits directly upstream of the single-port 32x1 select-RAM cells. It generates their write enable, address and data, and consumes their asynchronous read output.
- Provides first-word-fall-through read data, full/empty flags, almost-full/almost-empty flags, an occupancy count and sticky error flags.
- Used as a small elastic buffer between pipeline stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word (one 32x1 RAM column per bit).
- AFULL_LVL, 28, AFULL asserts when LEVEL >= AFULL_LVL (legal 1..32).
- AEMPTY_LVL, 4, AEMPTY asserts when LEVEL <= AEMPTY_LVL (legal 0..31).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  write request.
- WR_DATA  in  DATA_WIDTH  write data.
- FULL  out  1  FIFO holds 32 words.
- AFULL  out  1  almost full.
- RD_EN  in  1  read/pop request.
- RD_DATA  out  DATA_WIDTH  head-of-FIFO word (FWFT); valid whenever EMPTY=0.
- EMPTY  out  1  FIFO holds 0 words.
- AEMPTY  out  1  almost empty.
- LEVEL  out  6  occupancy, 0..32.
- OVF  out  1  sticky overflow error.
- UNF  out  1  sticky underflow error.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Storage:
  - 32 x DATA_WIDTH array.
  - Written on the CLK rising edge at address wr_ptr when a write is accepted.
  - Read combinationally at address rd_ptr.
  - Array contents are not reset; power-up value is 0.
- Pointers:
  - wr_ptr and rd_ptr are 5-bit counters that wrap 31 -> 0 naturally.
  - Full/empty are disambiguated by LEVEL, not by pointer comparison.
- Acceptance:
  - A write is accepted iff WR_EN=1 and FULL=0.
  - A read is accepted iff RD_EN=1 and EMPTY=0.
  - Both are evaluated on the same edge and independently.
- Per edge, with no reset:
  - Accepted write: mem[wr_ptr] <= WR_DATA; wr_ptr <= wr_ptr+1.
  - Accepted read: rd_ptr <= rd_ptr+1.
  - LEVEL <= LEVEL + wr_acc - rd_acc. Simultaneous accepted read and write leaves LEVEL unchanged.
- Flags are registered and computed from the next LEVEL, so they are exact in the cycle after the edge. There is no extra lag:
  - FULL = (LEVEL==32)
  - EMPTY = (LEVEL==0)
  - AFULL = (LEVEL>=AFULL_LVL)
  - AEMPTY = (LEVEL<=AEMPTY_LVL)
- Latency: a word written at edge k appears on RD_DATA, with EMPTY=0, in the cycle following edge k (one-cycle write-to-read latency).
- RD_DATA: equals mem[rd_ptr] combinationally. It is don't-care when EMPTY=1 and must not be checked then.
- Boundary, empty with WR_EN and RD_EN both high: only the write is accepted. LEVEL -> 1; UNF is set.
- Boundary, full with WR_EN and RD_EN both high: only the read is accepted. LEVEL -> 31; OVF is set; the written word is dropped.
- Errors:
  - OVF is set on any edge with WR_EN=1 and FULL=1.
  - UNF is set on any edge with RD_EN=1 and EMPTY=1.
  - Both are sticky and cleared only by RST.
- Reset:
  - Values: wr_ptr=0, rd_ptr=0, LEVEL=0, EMPTY=1, FULL=0, AEMPTY=1, AFULL=0 (unless AFULL_LVL==0, which is illegal), OVF=0, UNF=0.
  - Reset has priority over WR_EN/RD_EN in the same cycle. No write to the array occurs on a reset edge.
  - Reset mid-operation discards all contents logically; stale RAM data is never presented as valid.
- No combinational path from WR_EN/RD_EN to any flag output.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive edges -> after the 1st edge EMPTY=0 and RD_DATA=0x11; after the 3rd edge LEVEL=3 and AEMPTY=1. Pop 3 times -> RD_DATA shows 0x22, then 0x33; EMPTY=1 and LEVEL=0 after the 3rd pop.
- Write 32 words 0x00..0x1F -> AFULL rises when LEVEL=28 and FULL when LEVEL=32. A 33rd write of 0xAA -> OVF=1, LEVEL stays 32. Drain all 32 -> reads return 0x00..0x1F in order, with no 0xAA.
- Pointer wrap: repeat 20 writes then 20 reads, three times (60 words, pointers wrap) -> data is in order, LEVEL peaks at 20, and EMPTY=1 at the end.
- Simultaneous R/W at LEVEL=5 for 10 edges -> LEVEL stays 5 and output order is preserved. At LEVEL=0 with both high -> LEVEL=1, UNF=1. At LEVEL=32 with both high -> LEVEL=31, OVF=1.
- RST asserted at LEVEL=17 together with WR_EN=1 -> next cycle LEVEL=0, EMPTY=1, OVF=0, UNF=0. A following write of 0x5C -> RD_DATA=0x5C.
- Pop while empty immediately after reset -> UNF=1, LEVEL stays 0. UNF stays 1 through subsequent normal traffic until RST.

Source files
------------

// File: rtl/lutram_fifo32_if.sv
// Handshake and status bundle between a producer/consumer pair and lutram_fifo32.
`timescale 1ns/1ps
interface lutram_fifo32_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  afull;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  aempty;
    logic [5:0]            level;
    logic                  ovf;
    logic                  unf;

    // Pipeline stage driving writes/pops and observing the FIFO state.
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, afull, rd_data, empty, aempty, level, ovf, unf
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, afull, rd_data, empty, aempty, level, ovf, unf
    );
endinterface

// File: rtl/lutram_fifo32.sv
// 32-entry first-word-fall-through FIFO on a 32 x DATA_WIDTH distributed RAM
// (synchronous write, asynchronous read). Flags are registered from the next
// occupancy so they are exact one cycle after each edge, with no combinational
// path from the request inputs.
`timescale 1ns/1ps
module lutram_fifo32 #(
    parameter int DATA_WIDTH = 8,
    parameter int AFULL_LVL  = 28,
    parameter int AEMPTY_LVL = 4
) (
    input  logic           CLK,
    input  logic           RST,
    lutram_fifo32_if.slave bus
);
    localparam logic [5:0] AFULL_TH  = 6'(AFULL_LVL);
    localparam logic [5:0] AEMPTY_TH = 6'(AEMPTY_LVL);
    localparam logic [5:0] DEPTH     = 6'd32;

    logic [4:0]            wr_ptr;
    logic [4:0]            rd_ptr;
    logic [5:0]            level_q;
    logic [5:0]            level_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem [32];

    // Acceptance uses only registered flags, so each side is independent.
    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    // Next occupancy; a simultaneous accepted read and write cancel out.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        level_nxt = level_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + 6'd1;
            2'b01:   level_nxt = level_q - 6'd1;
            default: level_nxt = level_q;
        endcase
    end

    // Pointers, occupancy, flags and sticky errors.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            wr_ptr   <= 5'd0;
            rd_ptr   <= 5'd0;
            level_q  <= 6'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 5'd1;
            if (rd_acc) rd_ptr <= rd_ptr + 5'd1;
            level_q  <= level_nxt;
            full_q   <= (level_nxt == DEPTH);
            empty_q  <= (level_nxt == 6'd0);
            afull_q  <= (level_nxt >= AFULL_TH);
            aempty_q <= (level_nxt <= AEMPTY_TH);
            ovf_q    <= ovf_q | (bus.wr_en & full_q);
            unf_q    <= unf_q | (bus.rd_en & empty_q);
        end
    end

    // Distributed RAM write port; reset only blocks the write.
    always_ff @(posedge CLK) begin
        // NOTE: the array is deliberately not reset; LEVEL/EMPTY decide validity, so stale words are never shown as valid.
        if (!RST && wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    // Asynchronous read of the head entry gives first-word-fall-through data.
    assign bus.rd_data = mem[rd_ptr];
    assign bus.level   = level_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.afull   = afull_q;
    assign bus.aempty  = aempty_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
endmodule

// File: tb/tb_lutram_fifo32.sv
// Self-checking bench for lutram_fifo32: a vector table for the basic flow,
// then hand-written sequences for fill/overflow, pointer wrap, simultaneous
// read/write and reset corner cases. A queue model tracks the expected
// contents and flags after every clock edge.
`timescale 1ns/1ps
module tb_lutram_fifo32;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    lutram_fifo32_if #(.DATA_WIDTH(8)) bus ();

    lutram_fifo32 #(
        .DATA_WIDTH(8),
        .AFULL_LVL (28),
        .AEMPTY_LVL(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        bit         rst;
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        int         lvl;
        bit         emp;
        bit         unf;
        int         head;   // -1: head word not checked
    } vec_t;

    vec_t       vecs [9];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    int         peak  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_state();
        int n;
        n = sb.size();
        check("level",  int'(bus.level),  n);
        check("empty",  int'(bus.empty),  int'(n == 0));
        check("full",   int'(bus.full),   int'(n == 32));
        check("afull",  int'(bus.afull),  int'(n >= 28));
        check("aempty", int'(bus.aempty), int'(n <= 4));
        check("ovf",    int'(bus.ovf),    int'(m_ovf));
        check("unf",    int'(bus.unf),    int'(m_unf));
        if (n > 0) check("rd_data", int'(bus.rd_data), int'(sb[0]));
        if (int'(bus.level) > peak) peak = int'(bus.level);
    endtask

    // Drive one edge's worth of inputs, advance the model, then check.
    task automatic step(input bit rst, input bit wr, input logic [7:0] wd, input bit rd);
        bit wa;
        bit ra;
        @(negedge CLK);
        RST         = rst;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        @(posedge CLK);
        #1;
        if (rst) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wa = wr && (sb.size() < 32);
            ra = rd && (sb.size() > 0);
            if (wr && sb.size() == 32) m_ovf = 1'b1;
            if (rd && sb.size() == 0)  m_unf = 1'b1;
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(wd);
        end
        check_state();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RST         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;

        //         rst  wr  wd     rd   lvl emp unf head
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, -1};  // pop while empty
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 'h11};
        vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 'h11};
        vecs[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 'h11};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 'h22};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 'h33};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, -1};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            check($sformatf("vec%0d_level", i), int'(bus.level), vecs[i].lvl);
            check($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vecs[i].emp));
            check($sformatf("vec%0d_unf", i),   int'(bus.unf),   int'(vecs[i].unf));
            if (vecs[i].head >= 0)
                check($sformatf("vec%0d_head", i), int'(bus.rd_data), vecs[i].head);
        end
        check("basic_aempty_at_3", int'(bus.aempty), 1);

        // UNF stays set through normal traffic until reset.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_sticky", int'(bus.unf), 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("unf_cleared", int'(bus.unf), 0);

        // Fill to 32, overflow with 0xAA, drain in order.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            if (i == 26) check("afull_below_28", int'(bus.afull), 0);
            if (i == 27) check("afull_at_28",    int'(bus.afull), 1);
            if (i == 30) check("full_at_31",     int'(bus.full),  0);
        end
        check("full_at_32", int'(bus.full), 1);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        check("ovf_after_33rd", int'(bus.ovf),   1);
        check("level_after_33rd", int'(bus.level), 32);
        for (int i = 0; i < 32; i++) begin
            check("drain_head", int'(bus.rd_data), i);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", int'(bus.empty), 1);

        // Pointer wrap: three rounds of 20 writes then 20 reads.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        peak = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(r * 20 + i + 1), 1'b0);
            for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("wrap_peak",  peak, 20);
        check("wrap_empty", int'(bus.empty), 1);

        // Simultaneous read/write at LEVEL=5.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
            check("simul_level", int'(bus.level), 5);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("simul_drained", int'(bus.empty), 1);

        // Both high while empty: only the write lands.
        step(1'b0, 1'b1, 8'h77, 1'b1);
        check("empty_both_level", int'(bus.level),   1);
        check("empty_both_unf",   int'(bus.unf),     1);
        check("empty_both_head",  int'(bus.rd_data), 'h77);

        // Both high while full: only the read lands, write dropped.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        check("full_both_level", int'(bus.level), 31);
        check("full_both_ovf",   int'(bus.ovf),   1);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("full_both_drained", int'(bus.empty), 1);

        // Reset at LEVEL=17 with WR_EN high.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        check("pre_rst_level", int'(bus.level), 17);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        check("rst17_level", int'(bus.level), 0);
        check("rst17_empty", int'(bus.empty), 1);
        check("rst17_ovf",   int'(bus.ovf),   0);
        check("rst17_unf",   int'(bus.unf),   0);
        step(1'b0, 1'b1, 8'h5C, 1'b0);
        check("post_rst_head", int'(bus.rd_data), 'h5C);
        check("post_rst_level", int'(bus.level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
